// File: rtl/mcode_seq.sv
// Microcode sequencer: holds IR/STATE and addresses a synchronous microcode ROM with {IR, STATE}.
// Latency: the ROM address is one step ahead, so a new microword appears every advancing cycle.
// Backpressure: EN=0 or RDY=0 freezes IR/STATE and re-reads the current word, so MI stays stable.
module mcode_seq #(
    parameter int               MCODE_W   = 55,
    parameter int               STC_LSB   = 44,
    parameter int               STATE_W   = 4,
    parameter int               OPC_W     = 8,
    parameter logic [OPC_W-1:0] RESET_OPC = '0,
    parameter logic [OPC_W-1:0] IRQ_OPC   = '0,
    parameter int               CNT_W     = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     EN,
    input  logic                     RDY,
    input  logic [OPC_W-1:0]         OPC_IN,
    input  logic                     IRQ_PEND,
    input  logic [2:0]               COND,
    output logic [OPC_W+STATE_W-1:0] ROM_ADDR,
    input  logic [MCODE_W-1:0]       ROM_DATA,
    output logic [MCODE_W-1:0]       MI,
    output logic                     MI_VALID,
    output logic [OPC_W-1:0]         IR,
    output logic [STATE_W-1:0]       STATE,
    output logic                     LAST_CYCLE,
    output logic                     SEQ_ERR,
    output logic [CNT_W-1:0]         INSN_CNT
);

    localparam logic [2:0] SC_NEXT    = 3'b000;
    localparam logic [2:0] SC_END     = 3'b001;
    localparam logic [2:0] SC_SKIP0   = 3'b010;
    localparam logic [2:0] SC_SKIP1   = 3'b011;
    localparam logic [2:0] SC_SKIP2   = 3'b100;
    localparam logic [2:0] SC_HOLD    = 3'b101;
    localparam logic [2:0] SC_RESTART = 3'b110;

    logic [OPC_W-1:0]   ir_q;
    logic [STATE_W-1:0] state_q;
    logic               mi_valid_q;
    logic               seq_err_q;
    logic [CNT_W-1:0]   insn_cnt_q;

    logic [2:0]         sc;
    logic               adv;
    logic [OPC_W-1:0]   ir_nxt;
    logic [STATE_W-1:0] state_nxt;
    logic [STATE_W:0]   step;
    logic [STATE_W:0]   step_sum;
    logic               is_end;
    logic               ovf;

    assign sc  = ROM_DATA[STC_LSB+2:STC_LSB];
    assign adv = mi_valid_q & EN & RDY;

    // Sequencer registers; only an advancing cycle moves IR/STATE, so END under stall is deferred
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ir_q       <= RESET_OPC;
            state_q    <= '0;
            mi_valid_q <= 1'b0;
            seq_err_q  <= 1'b0;
            insn_cnt_q <= '0;
        end else begin
            mi_valid_q <= 1'b1;
            if (adv) begin
                ir_q    <= ir_nxt;
                state_q <= state_nxt;
                if (is_end) begin
                    insn_cnt_q <= insn_cnt_q + CNT_W'(1);
                end
                if (ovf) begin
                    seq_err_q <= 1'b1;
                end
            end
        end
    end

    // Next-step decode of the state-control field; the carry out of the STATE_W-bit add flags overflow
    always_comb begin
        ir_nxt    = ir_q;
        state_nxt = state_q;
        is_end    = 1'b0;
        ovf       = 1'b0;
        step      = '0;
        step_sum  = '0;
        case (sc)
            SC_END: begin
                is_end    = 1'b1;
                state_nxt = '0;
                ir_nxt    = IRQ_PEND ? IRQ_OPC : OPC_IN;
            end
            SC_SKIP0:   step = COND[0] ? (STATE_W+1)'(2) : (STATE_W+1)'(1);
            SC_SKIP1:   step = COND[1] ? (STATE_W+1)'(2) : (STATE_W+1)'(1);
            SC_SKIP2:   step = COND[2] ? (STATE_W+1)'(2) : (STATE_W+1)'(1);
            SC_HOLD:    step = '0;
            SC_RESTART: state_nxt = '0;
            SC_NEXT:    step = (STATE_W+1)'(1);
            default:    step = (STATE_W+1)'(1);
        endcase
        if (step != '0) begin
            step_sum  = {1'b0, state_q} + step;
            state_nxt = step_sum[STATE_W-1:0];
            ovf       = step_sum[STATE_W];
        end
    end

    // Outputs: ROM runs one step ahead while advancing, otherwise re-reads the current word
    always_comb begin
        ROM_ADDR   = adv ? {ir_nxt, state_nxt} : {ir_q, state_q};
        MI         = mi_valid_q ? ROM_DATA : '0;
        LAST_CYCLE = mi_valid_q & (sc == SC_END);
        MI_VALID   = mi_valid_q;
        IR         = ir_q;
        STATE      = state_q;
        SEQ_ERR    = seq_err_q;
        INSN_CNT   = insn_cnt_q;
    end

endmodule

// File: tb/tb_mcode_seq.sv
// Directed bench for mcode_seq with a behavioural synchronous microcode ROM.
// Expected IR/STATE are queued as each step is driven and popped after the clock edge.
// MI and LAST_CYCLE expectations come from the bench's own ROM image.
module tb_mcode_seq;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        EN;
    logic        RDY;
    logic [7:0]  OPC_IN;
    logic        IRQ_PEND;
    logic [2:0]  COND;
    logic [11:0] ROM_ADDR;
    logic [54:0] ROM_DATA;
    logic [54:0] MI;
    logic        MI_VALID;
    logic [7:0]  IR;
    logic [3:0]  STATE;
    logic        LAST_CYCLE;
    logic        SEQ_ERR;
    logic [15:0] INSN_CNT;

    logic [54:0] rom [0:4095];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] ir;
        logic [3:0] st;
    } exp_t;
    exp_t exp_q[$];

    mcode_seq dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .EN         (EN),
        .RDY        (RDY),
        .OPC_IN     (OPC_IN),
        .IRQ_PEND   (IRQ_PEND),
        .COND       (COND),
        .ROM_ADDR   (ROM_ADDR),
        .ROM_DATA   (ROM_DATA),
        .MI         (MI),
        .MI_VALID   (MI_VALID),
        .IR         (IR),
        .STATE      (STATE),
        .LAST_CYCLE (LAST_CYCLE),
        .SEQ_ERR    (SEQ_ERR),
        .INSN_CNT   (INSN_CNT)
    );

    always #5 CLK = ~CLK;

    // Synchronous ROM: data appears one clock after the address
    always @(posedge CLK) ROM_DATA <= rom[ROM_ADDR];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_sc(input logic [7:0] o, input logic [3:0] s, input logic [2:0] sc);
        logic [11:0] a;
        a = {o, s};
        rom[a][46:44] = sc;
    endtask

    // One clock: queue the expected step, let the edge happen, then compare
    task automatic cyc(input logic [7:0] ir, input logic [3:0] st);
        exp_t        e;
        exp_t        g;
        logic [11:0] a;
        logic [54:0] w;
        e.ir = ir;
        e.st = st;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        g = exp_q.pop_front();
        a = {g.ir, g.st};
        w = rom[a];
        chk("ir",       64'(IR),         64'(g.ir));
        chk("state",    64'(STATE),      64'(g.st));
        chk("mi",       64'(MI),         64'(w));
        chk("last",     64'(LAST_CYCLE), 64'(w[46:44] == 3'b001));
        chk("mi_valid", 64'(MI_VALID),   64'(1));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ir"},       64'(IR),       64'(0));
        chk({tag, "_state"},    64'(STATE),    64'(0));
        chk({tag, "_mi_valid"}, 64'(MI_VALID), 64'(0));
        chk({tag, "_mi"},       64'(MI),       64'(0));
        chk({tag, "_seq_err"},  64'(SEQ_ERR),  64'(0));
        chk({tag, "_cnt"},      64'(INSN_CNT), 64'(0));
        chk({tag, "_rom_addr"}, 64'(ROM_ADDR), 64'(0));
    endtask

    initial begin
        logic [7:0] o;
        logic [7:0] nxt;

        // ROM image: every word carries its own address as a tag, state-control defaults to NEXT
        for (int a = 0; a < 4096; a++) rom[a] = 55'(a) | (55'(a) << 20);
        set_sc(8'h00, 4'd2, 3'b001);
        set_sc(8'h01, 4'd0, 3'b001);
        set_sc(8'hA9, 4'd2, 3'b001);
        set_sc(8'h10, 4'd1, 3'b010);
        set_sc(8'h10, 4'd3, 3'b001);
        set_sc(8'h11, 4'd1, 3'b011);
        set_sc(8'h11, 4'd3, 3'b001);
        set_sc(8'h12, 4'd1, 3'b100);
        set_sc(8'h12, 4'd3, 3'b001);
        set_sc(8'hEA, 4'd1, 3'b001);
        set_sc(8'hF0, 4'd0, 3'b010);
        set_sc(8'hF0, 4'd1, 3'b001);
        set_sc(8'hF1, 4'd0, 3'b010);
        set_sc(8'hF1, 4'd1, 3'b001);
        set_sc(8'hF1, 4'd14, 3'b010);
        set_sc(8'h20, 4'd0, 3'b010);
        set_sc(8'h20, 4'd1, 3'b110);
        set_sc(8'h20, 4'd2, 3'b111);
        set_sc(8'h20, 4'd5, 3'b101);

        RST_N    = 1'b0;
        EN       = 1'b1;
        RDY      = 1'b1;
        OPC_IN   = 8'hA9;
        IRQ_PEND = 1'b0;
        COND     = 3'b000;

        // Reset, then run opcode 00 to its END and fetch A9
        #12;
        chk_reset_state("reset");
        RST_N = 1'b1;
        #1;
        chk("first_cycle_mi_valid", 64'(MI_VALID), 64'(0));
        cyc(8'h00, 4'd0);
        cyc(8'h00, 4'd1);
        cyc(8'h00, 4'd2);
        cyc(8'hA9, 4'd0);
        chk("cnt_after_first", 64'(INSN_CNT), 64'(1));

        // Stall at A9 step 1, then an EN=0 cycle
        cyc(8'hA9, 4'd1);
        RDY = 1'b0;
        #1;
        chk("stall_rom_addr", 64'(ROM_ADDR), 64'(12'hA91));
        for (int i = 0; i < 3; i++) begin
            cyc(8'hA9, 4'd1);
            chk("stall_rom_addr", 64'(ROM_ADDR), 64'(12'hA91));
        end
        EN  = 1'b0;
        RDY = 1'b1;
        cyc(8'hA9, 4'd1);
        EN = 1'b1;
        #1;
        chk("lookahead_rom_addr", 64'(ROM_ADDR), 64'(12'hA92));
        cyc(8'hA9, 4'd2);

        // END while stalled: nothing moves, opcode is resampled when it advances
        RDY    = 1'b0;
        OPC_IN = 8'hEA;
        cyc(8'hA9, 4'd2);
        chk("cnt_end_stall", 64'(INSN_CNT), 64'(1));
        OPC_IN = 8'h10;
        RDY    = 1'b1;
        cyc(8'h10, 4'd0);
        chk("cnt_end_resume", 64'(INSN_CNT), 64'(2));

        // Conditional skips on COND[0], COND[1], COND[2]; other COND bits must not matter
        for (int k = 0; k < 3; k++) begin
            o    = 8'h10 + 8'(k);
            nxt  = (k < 2) ? o + 8'h01 : 8'hEA;
            COND = ~(3'b001 << k);
            cyc(o, 4'd1);
            cyc(o, 4'd2);
            OPC_IN = o;
            cyc(o, 4'd3);
            cyc(o, 4'd0);
            cyc(o, 4'd1);
            COND = 3'b001 << k;
            cyc(o, 4'd3);
            OPC_IN = nxt;
            cyc(nxt, 4'd0);
        end
        COND = 3'b000;

        // Interrupt: ignored mid-instruction, taken at END
        IRQ_PEND = 1'b1;
        cyc(8'hEA, 4'd1);
        cyc(8'h00, 4'd0);
        IRQ_PEND = 1'b0;
        chk("cnt_after_irq", 64'(INSN_CNT), 64'(9));
        cyc(8'h00, 4'd1);
        OPC_IN = 8'hF0;
        cyc(8'h00, 4'd2);
        cyc(8'hF0, 4'd0);

        // Overflow by +1 from step 15
        COND = 3'b001;
        cyc(8'hF0, 4'd2);
        for (int s = 3; s < 16; s++) cyc(8'hF0, 4'(s));
        chk("seq_err_before_wrap", 64'(SEQ_ERR), 64'(0));
        cyc(8'hF0, 4'd0);
        chk("seq_err_wrap_inc", 64'(SEQ_ERR), 64'(1));
        COND = 3'b000;
        cyc(8'hF0, 4'd1);
        OPC_IN = 8'hA9;
        cyc(8'hA9, 4'd0);
        cyc(8'hA9, 4'd1);
        cyc(8'hA9, 4'd2);
        chk("seq_err_sticky", 64'(SEQ_ERR), 64'(1));

        // Reset pulse between edges clears the sticky flag
        RST_N = 1'b0;
        #1;
        chk_reset_state("pulse");
        #1;
        RST_N = 1'b1;
        cyc(8'h00, 4'd0);
        cyc(8'h00, 4'd1);
        OPC_IN = 8'hF1;
        cyc(8'h00, 4'd2);
        cyc(8'hF1, 4'd0);

        // Overflow by +2 from step 14
        COND = 3'b001;
        cyc(8'hF1, 4'd2);
        for (int s = 3; s < 15; s++) cyc(8'hF1, 4'(s));
        chk("seq_err_before_skip", 64'(SEQ_ERR), 64'(0));
        cyc(8'hF1, 4'd0);
        chk("seq_err_wrap_skip", 64'(SEQ_ERR), 64'(1));
        COND = 3'b000;
        cyc(8'hF1, 4'd1);
        OPC_IN = 8'h20;
        cyc(8'h20, 4'd0);

        // Restart keeps IR, reserved code steps by one, HOLD parks at step 5
        cyc(8'h20, 4'd1);
        cyc(8'h20, 4'd0);
        COND = 3'b001;
        cyc(8'h20, 4'd2);
        cyc(8'h20, 4'd3);
        cyc(8'h20, 4'd4);
        cyc(8'h20, 4'd5);
        cyc(8'h20, 4'd5);
        cyc(8'h20, 4'd5);

        // Asynchronous reset mid-instruction, no clock edge needed
        #3;
        RST_N = 1'b0;
        #1;
        chk_reset_state("async");
        #1;
        RST_N  = 1'b1;
        COND   = 3'b000;
        OPC_IN = 8'h01;
        cyc(8'h00, 4'd0);
        cyc(8'h00, 4'd1);
        cyc(8'h00, 4'd2);
        cyc(8'h01, 4'd0);
        chk("cnt_restart", 64'(INSN_CNT), 64'(1));

        // Single-step opcode 01 retires every cycle: run the counter up to its wrap
        repeat (65534) @(posedge CLK);
        #1;
        chk("cnt_max", 64'(INSN_CNT), 64'(16'hFFFF));
        cyc(8'h01, 4'd0);
        chk("cnt_wrap", 64'(INSN_CNT), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
